// File: rtl/zone_alarm_ctrl.sv
// zone_alarm_ctrl: armed/disarmed zone alarm with exit/entry delays, night mask and latched trip record
// Ports: clk, rst_n (async active-low); arm_away, arm_night, disarm requests;
//        zone_secure[ZONES] (1 = closed); state_o (DISARMED=0 EXIT=1 AWAY=2 NIGHT=3 ENTRY=4 ALARM=5);
//        alarm, armed, exit_pending, entry_pending decoded from state; arm_fail one-cycle refusal pulse;
//        tripped[ZONES] latched violated monitored zones, cleared by disarm or a new arming.
module zone_alarm_ctrl #(
  parameter int ZONES = 3,
  parameter logic [ZONES-1:0] NIGHT_MASK = 3'b110,
  parameter logic [ZONES-1:0] ENTRY_MASK = 3'b010,
  parameter int EXIT_CYCLES = 8,
  parameter int ENTRY_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_away,
  input  logic             arm_night,
  input  logic             disarm,
  input  logic [ZONES-1:0] zone_secure,
  output logic [2:0]       state_o,
  output logic             alarm,
  output logic             armed,
  output logic             exit_pending,
  output logic             entry_pending,
  output logic             arm_fail,
  output logic [ZONES-1:0] tripped
);
  localparam logic [2:0] DISARMED = 3'd0;
  localparam logic [2:0] EXIT     = 3'd1;
  localparam logic [2:0] AWAY     = 3'd2;
  localparam logic [2:0] NIGHT    = 3'd3;
  localparam logic [2:0] ENTRY    = 3'd4;
  localparam logic [2:0] ALARM    = 3'd5;
  localparam int MAXC = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  // Delays load N-1 and leave on the zero count, giving exactly N cycles in the delay state.
  localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_CYCLES - 1);
  localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ZONES-1:0] trip_d;
  logic             fail_d;
  logic [ZONES-1:0] v;
  logic             hard_hit, entry_hit, night_hit, cnt_zero;

  assign v         = ~zone_secure;
  assign hard_hit  = |(v & ~ENTRY_MASK);
  assign entry_hit = |(v & ENTRY_MASK);
  assign night_hit = |(v & NIGHT_MASK);
  assign cnt_zero  = cnt_q == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DISARMED;
      cnt_q    <= '0;
      tripped  <= '0;
      arm_fail <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tripped  <= trip_d;
      arm_fail <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trip_d  = tripped;
    fail_d  = 1'b0;
    if (disarm) begin
      state_d = DISARMED;
      cnt_d   = '0;
      trip_d  = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (arm_away) begin
            state_d = &zone_secure ? EXIT : DISARMED;
            cnt_d   = &zone_secure ? EXIT_LD : cnt_q;
            trip_d  = &zone_secure ? '0 : tripped;
            fail_d  = ~&zone_secure;
          end else if (arm_night) begin
            state_d = night_hit ? DISARMED : NIGHT;
            trip_d  = night_hit ? tripped : '0;
            fail_d  = night_hit;
          end
        end
        EXIT: begin
          state_d = cnt_zero ? AWAY : EXIT;
          cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
        end
        AWAY: begin
          trip_d  = tripped | v;
          state_d = hard_hit ? ALARM : entry_hit ? ENTRY : AWAY;
          cnt_d   = (!hard_hit && entry_hit) ? ENTRY_LD : cnt_q;
        end
        ENTRY: begin
          // Re-securing the entry zone does not cancel the delay; only disarm does.
          trip_d  = tripped | v;
          state_d = (hard_hit || cnt_zero) ? ALARM : ENTRY;
          cnt_d   = (hard_hit || cnt_zero) ? cnt_q : cnt_q - CW'(1);
        end
        NIGHT: begin
          trip_d  = tripped | (v & NIGHT_MASK);
          state_d = night_hit ? ALARM : NIGHT;
        end
        ALARM: trip_d = tripped | v;
        default: begin
          state_d = DISARMED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    state_o       = state_q;
    alarm         = state_q == ALARM;
    armed         = (state_q == AWAY) || (state_q == NIGHT) || (state_q == ENTRY);
    exit_pending  = state_q == EXIT;
    entry_pending = state_q == ENTRY;
  end
endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// tb_zone_alarm_ctrl: scoreboard bench for zone_alarm_ctrl with directed vectors at default parameters
module tb_zone_alarm_ctrl;
  localparam logic [2:0] DIS = 3'd0, EXT = 3'd1, AWY = 3'd2, NGT = 3'd3, ENT = 3'd4, ALM = 3'd5;

  typedef struct {
    int         cyc;
    logic [10:0] v;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm_away = 1'b0, arm_night = 1'b0, disarm = 1'b0;
  logic [2:0] zone_secure = 3'b111;
  logic [2:0] state_o, tripped;
  logic       alarm, armed, exit_pending, entry_pending, arm_fail;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       e;
  logic [10:0] got;

  zone_alarm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .arm_away(arm_away), .arm_night(arm_night), .disarm(disarm),
    .zone_secure(zone_secure), .state_o(state_o), .alarm(alarm), .armed(armed),
    .exit_pending(exit_pending), .entry_pending(entry_pending), .arm_fail(arm_fail), .tripped(tripped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] pk(input logic [2:0] st, input logic f, input logic [2:0] tr);
    return {st, st == ALM, st == AWY || st == NGT || st == ENT, st == EXT, st == ENT, f, tr};
  endfunction

  always @(negedge clk or negedge rst_n) begin
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      got = {state_o, alarm, armed, exit_pending, entry_pending, arm_fail, tripped};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s cyc %0d: got st=%0d al=%b ar=%b ex=%b en=%b fail=%b trip=%b, expected st=%0d al=%b ar=%b ex=%b en=%b fail=%b trip=%b",
                 e.nm, cyc, got[10:8], got[7], got[6], got[5], got[4], got[3], got[2:0],
                 e.v[10:8], e.v[7], e.v[6], e.v[5], e.v[4], e.v[3], e.v[2:0]);
      end
    end
  end

  task automatic step(input logic aa, input logic an, input logic dis, input logic [2:0] zs,
                      input logic [2:0] st, input logic f, input logic [2:0] tr, input string nm);
    arm_away = aa;
    arm_night = an;
    disarm = dis;
    zone_secure = zs;
    q.push_back('{cyc + 1, pk(st, f, tr), nm});
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    q.push_back('{cyc, pk(DIS, 1'b0, 3'b000), nm});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic go_away();
    step(1, 0, 0, 3'b111, EXT, 0, 3'b000, "arm_away");
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, (i == 2) ? 3'b011 : 3'b111, (i < 7) ? EXT : AWY, 0, 3'b000, (i < 7) ? "exit" : "away");
  endtask

  initial begin
    q.push_back('{0, pk(DIS, 1'b0, 3'b000), "reset"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    go_away();
    step(0, 0, 0, 3'b101, ENT, 0, 3'b010, "door_open");
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 3'b111, (i < 7) ? ENT : ALM, 0, 3'b010, (i < 7) ? "entry" : "entry_timeout");
    step(0, 0, 0, 3'b111, ALM, 0, 3'b010, "alarm_latched");
    step(1, 1, 0, 3'b111, ALM, 0, 3'b010, "alarm_ignores_arm");
    step(0, 0, 1, 3'b111, DIS, 0, 3'b000, "disarm_clears");
    go_away();
    step(0, 0, 0, 3'b101, ENT, 0, 3'b010, "door_open2");
    step(0, 0, 0, 3'b111, ENT, 0, 3'b010, "entry2");
    step(0, 0, 0, 3'b111, ENT, 0, 3'b010, "entry3");
    step(0, 0, 0, 3'b001, ALM, 0, 3'b110, "entry_preempt");
    step(0, 0, 1, 3'b111, DIS, 0, 3'b000, "disarm2");
    step(0, 1, 0, 3'b110, NGT, 0, 3'b000, "arm_night_z0_open");
    step(0, 0, 0, 3'b111, NGT, 0, 3'b000, "night_z0_close");
    step(0, 0, 0, 3'b110, NGT, 0, 3'b000, "night_z0_open");
    step(0, 0, 0, 3'b010, ALM, 0, 3'b100, "night_z2_open");
    step(0, 0, 1, 3'b111, DIS, 0, 3'b000, "disarm3");
    step(1, 0, 0, 3'b011, DIS, 1, 3'b000, "away_refused");
    step(0, 0, 0, 3'b011, DIS, 0, 3'b000, "fail_one_cycle");
    step(0, 1, 0, 3'b011, DIS, 1, 3'b000, "night_refused");
    step(0, 0, 0, 3'b111, DIS, 0, 3'b000, "fail_drop");
    step(1, 1, 0, 3'b111, EXT, 0, 3'b000, "both_away_wins");
    step(0, 0, 0, 3'b111, EXT, 0, 3'b000, "exit_a");
    step(0, 0, 0, 3'b111, EXT, 0, 3'b000, "exit_b");
    async_reset("reset_mid_exit");
    step(0, 0, 0, 3'b111, DIS, 0, 3'b000, "after_reset");
    go_away();
    step(0, 0, 0, 3'b111, AWY, 0, 3'b000, "away_hold");
    step(0, 0, 1, 3'b111, DIS, 0, 3'b000, "disarm4");
    step(0, 1, 0, 3'b111, NGT, 0, 3'b000, "arm_night");
    step(0, 0, 0, 3'b011, ALM, 0, 3'b100, "night_alarm");
    async_reset("reset_mid_alarm");
    go_away();
    step(0, 0, 0, 3'b101, ENT, 0, 3'b010, "door_open3");
    for (int i = 0; i < 7; i++)
      step(0, 0, 0, 3'b111, ENT, 0, 3'b010, "entry4");
    step(0, 0, 1, 3'b111, DIS, 0, 3'b000, "disarm_on_expiry");
    step(0, 0, 0, 3'b111, DIS, 0, 3'b000, "no_alarm_after");
    @(negedge clk);
    #3;
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL pending: %0d expectations never compared, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zone_alarm_ctrl.md
# zone_alarm_ctrl

Parametrised, clocked successor to the combinational home alarm. It monitors `ZONES` contact sensors (1 = secure) and supports two arming modes: away, and night with a maskable zone set. Away mode adds exit and entry delays. Once the alarm is raised it stays latched until disarm, and the block records which zones tripped. It sits between the keypad/mode inputs and the siren driver.

## Interface
- `ZONES`, default 3: number of sensor zones, 1..16.
- `NIGHT_MASK`, default 3'b110: zones monitored in night mode.
- `ENTRY_MASK`, default 3'b010: zones that start an entry delay in away mode rather than an immediate alarm.
- `EXIT_CYCLES`, default 8: exit-delay length, >=1.
- `ENTRY_CYCLES`, default 8: entry-delay length, >=1.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm_away`  in  1  request away arming; level-sampled.
- `arm_night`  in  1  request night arming; level-sampled.
- `disarm`  in  1  disarm / clear.
- `zone_secure`  in  ZONES  1 = zone closed, 0 = violated.
- `state_o`  out  3  encoding: DISARMED=0, EXIT=1, AWAY=2, NIGHT=3, ENTRY=4, ALARM=5.
- `alarm`  out  1  high iff state is ALARM.
- `armed`  out  1  high in AWAY, NIGHT or ENTRY.
- `exit_pending`  out  1  high in EXIT.
- `entry_pending`  out  1  high in ENTRY.
- `arm_fail`  out  1  one-cycle pulse when an arm request is refused.
- `tripped`  out  ZONES  latched record of violated monitored zones.

## Operation
- Reset (`rst_n`=0, asynchronous):
  - state = DISARMED.
  - delay counter = 0.
  - all outputs 0, including `tripped` = 0.
- Priority at every edge: `disarm` beats everything. From any state, the next state is DISARMED and `tripped` clears.
- DISARMED:
  - `arm_away` when `&zone_secure`: go to EXIT, load counter with `EXIT_CYCLES`-1.
  - `arm_away` when not all zones secure: stay in DISARMED, pulse `arm_fail`.
  - Otherwise, `arm_night` when all `NIGHT_MASK` zones are secure: go to NIGHT.
  - `arm_night` when any `NIGHT_MASK` zone is violated: pulse `arm_fail`.
  - If both requests are asserted together, away wins.
  - Entering EXIT or NIGHT clears `tripped`.
- EXIT:
  - Zones are ignored.
  - Counter decrements each cycle. When the counter is 0, go to AWAY.
- AWAY: let v = ~`zone_secure`.
  - Any violated zone outside `ENTRY_MASK`: go to ALARM.
  - Otherwise any violated `ENTRY_MASK` zone: go to ENTRY, load counter with `ENTRY_CYCLES`-1.
- ENTRY:
  - Any violated zone outside `ENTRY_MASK`: go to ALARM immediately.
  - Otherwise, counter == 0: go to ALARM.
  - Otherwise decrement the counter.
  - Re-securing the entry zone does not cancel the delay.
- NIGHT: any violated `NIGHT_MASK` zone goes to ALARM. There is no entry delay.
- ALARM: held until `disarm`. Arm requests are ignored.
- `tripped` update: in AWAY, ENTRY and ALARM, `tripped` |= v each cycle. In NIGHT, `tripped` |= v & `NIGHT_MASK`.
- Arm requests outside DISARMED are ignored, with no `arm_fail`.
- Counter width is `$clog2(max(EXIT_CYCLES, ENTRY_CYCLES))`, minimum 1 bit. The counter never wraps: it is only loaded or decremented while nonzero.

## Timing
- All outputs are registered or decoded from registered state. An input sampled at edge k is reflected in outputs after edge k, i.e. 1-cycle latency.
- EXIT lasts exactly `EXIT_CYCLES` cycles. ENTRY lasts exactly `ENTRY_CYCLES` cycles unless pre-empted.
- `arm_fail` is high for exactly the one cycle following the refusing edge.
- Reset mid-delay aborts immediately. No delay state survives reset.
- `disarm` on the same edge as the entry timeout: the result is DISARMED, `alarm` stays 0.

## Test plan
Benches use the defaults (`ZONES`=3, `NIGHT_MASK`=110, `ENTRY_MASK`=010, `EXIT_CYCLES`=`ENTRY_CYCLES`=8).
- Reset, then `zone_secure`=111, pulse `arm_away` -> `exit_pending`=1 for 8 cycles, then `armed`=1 with `state_o`=2; `arm_fail` stays 0.
- In AWAY, `zone_secure`=101 (door open) -> `entry_pending`=1 for 8 cycles, then `alarm`=1 with `tripped`=010. Re-close the door; `alarm` stays 1 until `disarm`, after which `state_o`=0 and `tripped`=000.
- In ENTRY at cycle 3, open zone 2 (`zone_secure`=001) -> `alarm`=1 the next cycle, `tripped`=110.
- `arm_night` with `zone_secure`=110 (zone 0 open, unmasked) -> NIGHT, `armed`=1. Zone 0 toggling causes no alarm. `zone_secure`=010 -> `alarm`=1 next cycle, `tripped`=100.
- `arm_away` with `zone_secure`=011 -> `arm_fail` pulses for 1 cycle and `state_o` stays 0. `arm_away` and `arm_night` together with 111 -> EXIT.
- Assert `rst_n`=0 mid-EXIT and mid-ALARM -> all outputs 0 asynchronously. `disarm` on the ENTRY-expiry edge -> `state_o`=0, `alarm` never asserts.
